// File: rtl/audio_sram_ctrl.sv
// rtl/audio_sram_ctrl.sv - record/playback sequencer and sole owner of the audio SRAM pins
module audio_sram_ctrl #(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_record,
  input  logic          cmd_play,
  input  logic          cmd_stop,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i,
  output logic          sram_ce_n,
  output logic          sram_we_n,
  output logic          sram_oe_n,
  output logic [1:0]    mode,
  output logic          full,
  output logic [AW:0]   rec_len
);

  typedef enum logic [1:0] {M_IDLE = 2'd0, M_REC = 2'd1, M_PLAY = 2'd2} mode_t;
  typedef enum logic [1:0] {AIDLE, S1, S2, S3} acc_t;

  mode_t       mode_q, mode_d;
  acc_t        acc_q, acc_d;
  logic        stop_pend_q, stop_pend_d;
  logic        op_wr_q, op_d;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        slot, stop_now;
  logic        accept_wr, accept_rd, start_rec, start_play;

  assign mode = mode_q;

  // Pointers advance at acceptance; every accepted access always runs to completion,
  // so wr_ptr equals the completed-write count whenever the mode can change.
  always_comb begin
    mode_d      = mode_q;
    acc_d       = AIDLE;
    stop_pend_d = stop_pend_q;
    accept_wr   = 1'b0;
    accept_rd   = 1'b0;
    start_rec   = 1'b0;
    start_play  = 1'b0;
    slot        = (acc_q == AIDLE) || (acc_q == S3);
    stop_now    = cmd_stop || stop_pend_q;

    case (acc_q)
      S1:      acc_d = S2;
      S2:      acc_d = S3;
      default: acc_d = AIDLE;
    endcase

    if (!slot) begin
      // A stop during C1/C2 is held until the access reaches its last edge.
      if (cmd_stop) stop_pend_d = 1'b1;
    end else if (stop_now) begin
      mode_d      = M_IDLE;
      stop_pend_d = 1'b0;
    end else begin
      case (mode_q)
        M_IDLE: begin
          if (cmd_record) begin
            mode_d    = M_REC;
            start_rec = 1'b1;
          end else if (cmd_play) begin
            mode_d     = M_PLAY;
            start_play = 1'b1;
          end
        end
        M_REC: begin
          if (wr_ptr[AW]) mode_d = M_IDLE;
          else if (wr_req) accept_wr = 1'b1;
        end
        M_PLAY: begin
          if (rd_ptr == rec_len) mode_d = M_IDLE;
          else if (rd_req) accept_rd = 1'b1;
        end
        default: mode_d = M_IDLE;
      endcase
    end

    if (accept_wr || accept_rd) acc_d = S1;
    op_d = (accept_wr || accept_rd) ? accept_wr : op_wr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= M_IDLE;
      acc_q       <= AIDLE;
      stop_pend_q <= 1'b0;
      op_wr_q     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rec_len     <= '0;
      full        <= 1'b0;
      wr_ack      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      sram_addr   <= '0;
      sram_dq_o   <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      stop_pend_q <= stop_pend_d;
      op_wr_q     <= op_d;
      wr_ack      <= accept_wr;
      rd_valid    <= (acc_q == S3) && !op_wr_q;
      if ((acc_q == S3) && !op_wr_q) rd_data <= sram_dq_i;

      if (start_rec) begin
        wr_ptr <= '0;
        full   <= 1'b0;
      end
      if (start_play) rd_ptr <= '0;
      if (accept_wr) wr_ptr <= wr_ptr + 1'b1;
      if (accept_rd) rd_ptr <= rd_ptr + 1'b1;

      if ((mode_q == M_REC) && (mode_d == M_IDLE)) begin
        rec_len <= wr_ptr;
        full    <= wr_ptr[AW];
      end

      if (accept_wr) begin
        sram_addr <= wr_ptr[AW-1:0];
        sram_dq_o <= wr_data;
      end else if (accept_rd) begin
        sram_addr <= rd_ptr[AW-1:0];
      end

      // Strobes follow the access state being entered, so each pin is a plain flop.
      sram_ce_n  <= (acc_d == AIDLE);
      sram_dq_oe <= (acc_d != AIDLE) && op_d;
      sram_we_n  <= !((acc_d == S2) && op_d);
      sram_oe_n  <= !(((acc_d == S2) || (acc_d == S3)) && !op_d);
    end
  end

endmodule

// File: tb/tb_audio_sram_ctrl.sv
// tb/tb_audio_sram_ctrl.sv - directed self-checking bench for audio_sram_ctrl
module tb_audio_sram_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_record, cmd_play, cmd_stop;
  logic          wr_req, rd_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack, rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n;
  logic [1:0]    mode;
  logic          full;
  logic [AW:0]   rec_len;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int ce_cycles = 0;

  audio_sram_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_record(cmd_record), .cmd_play(cmd_play), .cmd_stop(cmd_stop),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .mode(mode), .full(full), .rec_len(rec_len)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

  always @(posedge clk) begin
    if (wr_ack) ack_cnt++;
    if (!sram_ce_n) ce_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // pins packed as {dq_oe, ce_n, we_n, oe_n}
  task automatic do_write(input logic [DW-1:0] d, input logic [AW-1:0] a, input string tag);
    int n;
    wr_req = 1'b1;
    wr_data = d;
    n = 0;
    do begin tick(); n++; end while (!wr_ack && n < 8);
    wr_req = 1'b0;
    check({tag, " ack_latency"}, n, 1);
    check({tag, " addr"}, sram_addr, a);
    check({tag, " dq_o"}, sram_dq_o, d);
    check({tag, " C1 pins"}, {sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n}, 4'b1011);
    tick();
    check({tag, " C2 pins"}, {sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n}, 4'b1001);
    check({tag, " C2 ack low"}, wr_ack, 0);
    tick();
    check({tag, " C3 pins"}, {sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n}, 4'b1011);
  endtask

  initial begin
    int n, acks0, ce0, since, last_addr;
    rst_n = 1'b0;
    {cmd_record, cmd_play, cmd_stop, wr_req, rd_req} = '0;
    wr_data = '0;
    repeat (2) tick();
    check("rst pins", {sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n}, 4'b0111);
    check("rst outs", {wr_ack, rd_valid, mode, full}, 0);
    check("rst rec_len", rec_len, 0);
    check("rst addr/dq/rd", {sram_addr, sram_dq_o, rd_data}, 0);
    rst_n = 1'b1;
    tick();

    // Record five samples, a play command that must be ignored, then stop
    cmd_record = 1'b1; tick(); cmd_record = 1'b0;
    check("rec mode", mode, 1);
    acks0 = ack_cnt;
    for (int i = 0; i < 5; i++) do_write(16'hA000 + 16'(i), AW'(i), $sformatf("wr%0d", i));
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    check("play in rec ignored", mode, 1);
    check("released after write", {sram_dq_oe, sram_ce_n}, 2'b01);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    check("stop mode", mode, 0);
    check("rec_len 5", rec_len, 5);
    check("full after 5", full, 0);
    check("ack count 5", ack_cnt - acks0, 5);
    for (int i = 0; i < 5; i++) check($sformatf("mem[%0d]", i), mem[i], 16'hA000 + 16'(i));

    // Play back with rd_req held: back-to-back reads every 3 clocks
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    check("play mode", mode, 2);
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin tick(); n++; end while (!rd_valid && n < 8);
      check($sformatf("rd%0d latency", i), n, (i == 0) ? 4 : 3);
      check($sformatf("rd%0d data", i), rd_data, 16'hA000 + 16'(i));
    end
    check("play end mode", mode, 0);
    rd_req = 1'b0;
    tick();
    check("rd_valid pulse", rd_valid, 0);
    check("rd_data held", rd_data, 16'hA004);
    check("released after read", sram_ce_n, 1);

    // Requests outside their mode are never served
    acks0 = ack_cnt; ce0 = ce_cycles;
    wr_req = 1'b1; rd_req = 1'b1;
    repeat (6) tick();
    check("idle no ack", ack_cnt - acks0, 0);
    check("idle no strobe", ce_cycles - ce0, 0);
    rd_req = 1'b0;
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    check("gate play mode", mode, 2);
    repeat (6) tick();
    check("play no wr_ack", ack_cnt - acks0, 0);
    check("play no strobe", ce_cycles - ce0, 0);
    wr_req = 1'b0;
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    check("gate stop mode", mode, 0);

    // Stop during C2 of the third write
    cmd_record = 1'b1; tick(); cmd_record = 1'b0;
    do_write(16'hB000, 0, "sw0");
    do_write(16'hB001, 1, "sw1");
    wr_req = 1'b1; wr_data = 16'hB002;
    tick();
    wr_req = 1'b0;
    check("sw2 ack", wr_ack, 1);
    tick();
    check("sw2 C2 we_n", sram_we_n, 0);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    check("sw2 C3 pins", {sram_dq_oe, sram_ce_n, sram_we_n}, 3'b101);
    check("sw2 C3 mode", mode, 1);
    tick();
    check("sw2 after mode", mode, 0);
    check("sw2 rec_len", rec_len, 3);
    check("sw2 released", sram_ce_n, 1);
    check("sw2 mem", mem[2], 16'hB002);

    // Fill the whole array with a continuously held request
    cmd_record = 1'b1; tick(); cmd_record = 1'b0;
    acks0 = ack_cnt; since = 0; last_addr = -1;
    wr_req = 1'b1; wr_data = 16'hC000;
    n = 0;
    do begin
      tick(); n++;
      if (wr_ack) begin
        last_addr = int'(sram_addr);
        since = 0;
        wr_data = wr_data + 1'b1;
      end else since++;
    end while (mode != 0 && n < 80);
    check("fill mode", mode, 0);
    check("fill acks", ack_cnt - acks0, 16);
    check("fill last addr", last_addr, 15);
    check("fill idle timing", since, 3);
    check("fill full", full, 1);
    check("fill rec_len", rec_len, 5'h10);
    check("fill mem last", mem[15], 16'hC00F);
    acks0 = ack_cnt;
    repeat (6) tick();
    check("fill no more ack", ack_cnt - acks0, 0);
    wr_req = 1'b0;

    // Empty recording then play; record+stop together in IDLE
    cmd_record = 1'b1; tick(); cmd_record = 1'b0;
    check("empty rec full cleared", full, 0);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    check("empty rec_len", rec_len, 0);
    ce0 = ce_cycles;
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    check("empty play mode", mode, 2);
    tick();
    check("empty play back idle", mode, 0);
    tick();
    check("empty play no strobe", ce_cycles - ce0, 0);
    cmd_record = 1'b1; cmd_stop = 1'b1; tick(); cmd_record = 1'b0; cmd_stop = 1'b0;
    check("rec+stop mode", mode, 0);
    tick();
    check("rec+stop mode later", mode, 0);

    // Asynchronous reset while we_n is low
    cmd_record = 1'b1; tick(); cmd_record = 1'b0;
    wr_req = 1'b1; wr_data = 16'h5555;
    tick(); wr_req = 1'b0;
    tick();
    check("pre-reset we_n", sram_we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst pins", {sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n}, 4'b0111);
    check("async rst outs", {wr_ack, rd_valid, mode, full}, 0);
    check("async rst rec_len", rec_len, 0);
    check("async rst addr/dq", {sram_addr, sram_dq_o, rd_data}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_sram_ctrl.md
# audio_sram_ctrl

Sequencer and owner of the 256K×16 audio SRAM for the record/playback path. It accepts record/play/stop commands from the control interface. In RECORD it writes samples from the ADC capture block into SRAM at an internally kept address. In PLAY it serves read requests from the DAC playback block over the recorded range. It is the only block that drives the SRAM pins and runs a fixed 3-cycle access sequence.

## Interface
- AW, 18, SRAM address width
- DW, 16, SRAM data width
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_record / cmd_play / cmd_stop  in  1 each  single-cycle command pulses
- wr_req  in  1  sample write request (ADC side); held until wr_ack
- wr_data  in  DW  sample; captured on the accepting edge
- wr_ack  out  1  one-cycle pulse: write accepted
- rd_req  in  1  sample read request (DAC side); held until rd_valid
- rd_data  out  DW  read sample; stable from rd_valid until next read completes
- rd_valid  out  1  one-cycle pulse: rd_data valid
- sram_addr  out  AW  SRAM address
- sram_dq_o  out  DW  write data; sram_dq_oe=1 enables the external tristate
- sram_dq_oe  out  1  see sram_dq_o
- sram_dq_i  in  DW  SRAM read data
- sram_ce_n / sram_we_n / sram_oe_n  out  1 each  SRAM strobes, active low
- mode  out  2  0=IDLE, 1=RECORD, 2=PLAY
- full  out  1  SRAM filled by last recording
- rec_len  out  AW+1  words in last recording (0..2^AW)

## Operation
- Mode FSM (IDLE/RECORD/PLAY):
  - cmd_stop is accepted in any mode.
  - cmd_record and cmd_play are accepted only in IDLE.
  - Same-cycle priority: stop > record > play.
  - Commands not accepted in the current mode are ignored.
- IDLE→RECORD: wr_ptr:=0, full:=0.
- RECORD, per access: write at wr_ptr, then wr_ptr+1.
  - After the write at address 2^AW−1 completes: rec_len:=2^AW, full:=1, mode:=IDLE.
- RECORD→IDLE on stop: rec_len:=wr_ptr (completed writes only).
- IDLE→PLAY: rd_ptr:=0. If rec_len==0, return to IDLE the next cycle.
- PLAY, per access: read at rd_ptr, then rd_ptr+1.
  - After the read at rd_ptr==rec_len−1 completes, mode:=IDLE.
- Request gating:
  - wr_req is served only in RECORD; rd_req only in PLAY.
  - Otherwise the request is never acknowledged and stays pending with no effect.
- Access FSM (AIDLE, S1, S2, S3): one access at a time, no queueing.
- Stop arriving mid-access: the access finishes all cycles (including wr_ack/rd_valid), then mode becomes IDLE. A write finished this way counts in rec_len.
- Pointer arithmetic is AW+1 bits; no wrap-around ever occurs.

## Timing
- Reset values: all SRAM strobes =1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0, wr_ack=0, rd_valid=0, rd_data=0, mode=0, full=0, rec_len=0, pointers=0, access FSM=AIDLE.
- All outputs are registered.
- Acceptance edge E0: access FSM in AIDLE and a valid request for the current mode. The following cycles are C1, C2, C3.
- Write access:
  - C1: sram_addr=wr_ptr, sram_dq_o=wr_data, sram_dq_oe=1, ce_n=0, we_n=1, wr_ack=1.
  - C2: we_n=0.
  - C3: we_n=1, dq still driven.
  - After E3: ce_n=1, dq_oe=0, wr_ptr increments.
- Read access:
  - C1: sram_addr=rd_ptr, ce_n=0, oe_n=1.
  - C2–C3: oe_n=0.
  - At E3: rd_data:=sram_dq_i.
  - C4: rd_valid=1, strobes released.
- Access FSM returns to AIDLE at E3, so the next accept can occur at E3. Throughput is 1 access per 3 clocks.
- Requester rules: drop wr_req after seeing wr_ack; drop rd_req by the edge ending the rd_valid cycle. A request still high at E3 is a new request.
- Command latency: mode changes on the edge after the command cycle (visible 1 cycle later).
- Full completion: mode=IDLE and full=1 in the cycle after C3 of the final write.
- Async reset mid-access: all strobes are forced inactive immediately.

## Test plan
- Reset: assert rst_n=0 mid-write (we_n=0) → we_n, ce_n, oe_n =1 and dq_oe=0 at once; all outputs at reset values.
- Record then play:
  - cmd_record, 5 writes of 16'hA000+i, cmd_stop → rec_len=5, sram addresses 0..4, wr_ack once per write, one access per 3 clocks.
  - cmd_play, 5 reads → rd_data matches the written values; mode returns to IDLE after the 5th rd_valid.
- Gating: wr_req in IDLE and in PLAY → no wr_ack, no SRAM strobe. cmd_play while in RECORD → ignored, mode stays 1.
- Stop mid-access: cmd_stop during C2 of the 3rd write → we_n pulse completes, wr_ack seen, rec_len=3, mode=0 after C3.
- Fill: record 2^18 writes continuously → final write at 18'h3FFFF, full=1, rec_len=19'h40000, mode=0; further wr_req not acked.
- Edge commands: cmd_play with rec_len=0 → mode=2 for one cycle, then 0, no strobes. Simultaneous cmd_record+cmd_stop in IDLE → stays IDLE.
